// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with a 2-entry
// {inst, pc} queue and redirect/drop handling for late responses.
// Ports: clock, reset (async, high) | imem_req/addr/ready/rvalid/rdata
// to instruction memory | redirect, redirect_pc from branch resolution
// | inst_valid/inst/inst_pc/inst_ready queue head to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] q_inst [2];
  logic [31:0] q_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        accept;
  logic        push;
  logic        pop;

  // Gated by reset so nothing is requested while reset is held.
  assign imem_req = !reset && (state == RUN)
                 && (count != 2'd2) && !redirect;
  assign imem_addr = {fetch_pc[31:2], 2'b00};
  assign accept = imem_req && imem_ready;

  // A redirect kills both the arriving word and any consumption.
  assign push = (state == WAIT) && imem_rvalid && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  assign inst_valid = (count != 2'd0);
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:  if (accept) state_nx = WAIT;
      WAIT: begin
        if (imem_rvalid)   state_nx = RUN;
        else if (redirect) state_nx = DROP;
      end
      DROP: if (imem_rvalid) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      req_pc    <= RESET_PC;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      q_inst[0] <= 32'd0;
      q_inst[1] <= 32'd0;
      q_pc[0]   <= 32'd0;
      q_pc[1]   <= 32'd0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
      end else begin
        if (accept) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          q_inst[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr]   <= req_pc;
          wr_ptr         <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
// Memory responder with programmable latency; monitor pops on consume.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int          rsp_delay = 0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] acc_addr = 32'd0;
  int          n_acc = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Memory: word at address A returns {A[15:0], 16'hC0DE}.
  always @(negedge clock) begin
    imem_rvalid = 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = {paddr[15:0], 16'hC0DE};
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req && imem_ready) begin
        pend     = 1'b1;
        paddr    = imem_addr;
        cnt      = rsp_delay;
        acc_addr = imem_addr;
        n_acc++;
      end
    end
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && inst_valid && inst_ready && !redirect) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pop: got pc %h expected none",
                 inst_pc);
      end else begin
        e = sb.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.data);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_i(input logic [31:0] pc, input logic [31:0] d);
    exp_t e;
    e.pc   = pc;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string nm);
    int b;
    b = 0;
    while (sb.size() != 0 && b < 80) begin
      step();
      b++;
    end
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_req(input string nm);
    int b;
    b = 0;
    while (!imem_req && b < 30) begin
      step();
      b++;
    end
    chk(nm, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic wait_wait_state();
    int b;
    b = 0;
    while (imem_req && b < 30) begin
      step();
      b++;
    end
  endtask

  initial begin
    step(3);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);

    // Streaming, zero-wait memory
    expect_i(32'h0, 32'h0000_C0DE);
    expect_i(32'h4, 32'h0004_C0DE);
    expect_i(32'h8, 32'h0008_C0DE);
    reset = 1'b0;
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    wait_empty("p1_drained");
    wait_wait_state();
    reset = 1'b1;

    // Back-pressure fills the queue
    inst_ready = 1'b0;
    step(2);
    n_acc = 0;
    expect_i(32'h0, 32'h0000_C0DE);
    expect_i(32'h4, 32'h0004_C0DE);
    expect_i(32'h8, 32'h0008_C0DE);
    reset = 1'b0;
    step(12);
    chk("p2_accepts", 32'(n_acc), 32'd2);
    chk("p2_req_off", {31'd0, imem_req}, 32'd0);
    chk("p2_valid", {31'd0, inst_valid}, 32'd1);
    chk("p2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();
    chk("p2_resume_req", {31'd0, imem_req}, 32'd1);
    chk("p2_resume_addr", imem_addr, 32'h8);
    wait_empty("p2_drained");
    wait_wait_state();
    reset = 1'b1;

    // Memory stall on the second request
    step(2);
    expect_i(32'h0, 32'h0000_C0DE);
    expect_i(32'h4, 32'h0004_C0DE);
    expect_i(32'h8, 32'h0008_C0DE);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req && imem_addr == 32'h4) break;
    end
    imem_ready = 1'b0;
    chk("p3_req_seen", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("p3_hold_req", {31'd0, imem_req}, 32'd1);
      chk("p3_hold_addr", imem_addr, 32'h4);
    end
    imem_ready = 1'b1;
    wait_empty("p3_drained");
    wait_wait_state();
    reset = 1'b1;

    // Redirect with a slow response outstanding
    step(2);
    rsp_delay = 3;
    expect_i(32'h0, 32'h0000_C0DE);
    expect_i(32'h4, 32'h0004_C0DE);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sb.size() == 1) break;
    end
    inst_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pend && acc_addr == 32'h8) break;
    end
    chk("p4_outstanding", acc_addr, 32'h8);
    chk("p4_head_valid", {31'd0, inst_valid}, 32'd1);
    chk("p4_head_pc", inst_pc, 32'h4);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    sb.delete();
    expect_i(32'h100, 32'h0100_C0DE);
    #1;
    chk("p4_redir_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect  = 1'b0;
    rsp_delay = 0;
    #1;
    chk("p4_flushed", {31'd0, inst_valid}, 32'd0);
    chk("p4_drop_req", {31'd0, imem_req}, 32'd0);
    wait_req("p4_req_back");
    chk("p4_next_addr", imem_addr, 32'h100);
    inst_ready = 1'b1;
    wait_empty("p4_drained");
    wait_wait_state();
    reset = 1'b1;

    // Redirect coincident with rvalid and a ready consumer
    step(2);
    inst_ready = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (inst_valid) break;
    end
    chk("p5_valid", {31'd0, inst_valid}, 32'd1);
    step();
    chk("p5_in_wait", {31'd0, imem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    inst_ready  = 1'b1;
    expect_i(32'h200, 32'h0200_C0DE);
    step();
    redirect = 1'b0;
    #1;
    chk("p5_count0", {31'd0, inst_valid}, 32'd0);
    chk("p5_req", {31'd0, imem_req}, 32'd1);
    chk("p5_addr", imem_addr, 32'h200);
    wait_empty("p5_drained");
    wait_wait_state();
    reset = 1'b1;

    // Address wrap, then async reset while waiting
    step(2);
    expect_i(32'hFFFF_FFFC, 32'hFFFC_C0DE);
    expect_i(32'h0, 32'h0000_C0DE);
    reset       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("p6_redir_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("p6_req", {31'd0, imem_req}, 32'd1);
    chk("p6_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("p6_wrap_addr", imem_addr, 32'h0);
    wait_empty("p6_drained");
    wait_wait_state();
    reset = 1'b1;
    #1;
    chk("p6_rst_req", {31'd0, imem_req}, 32'd0);
    chk("p6_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("p6_rst_addr", imem_addr, 32'h0);
    step(2);
    expect_i(32'h0, 32'h0000_C0DE);
    reset = 1'b0;
    #1;
    chk("p6_post_req", {31'd0, imem_req}, 32'd1);
    chk("p6_post_addr", imem_addr, 32'h0);
    wait_empty("p6_post_drained");
    wait_wait_state();
    reset = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
